jelly_axi4_read_arbiter2: RTL and testbench

JELLY_AXI4_READ_ARBITER2 -- requirements
Module: jelly_axi4_read_arbiter2

---
 rtl/jelly_axi4_read_arbiter2.sv | 203 ++++++++++++++++++++
 tb/tb_jelly_axi4_read_arbiter2.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_axi4_read_arbiter2.sv
// Two-port AXI4 read arbiter: round-robin AR grant, one outstanding burst,
// R channel steered back to the granted port with an RLAST/ARLEN consistency flag.
module jelly_axi4_read_arbiter2 #(
    parameter  int unsigned AXI_ID_WIDTH   = 6,
    parameter  int unsigned AXI_ADDR_WIDTH = 32,
    parameter  int unsigned AXI_DATA_SIZE  = 3,
    localparam int unsigned AXI_DATA_WIDTH = 8 << AXI_DATA_SIZE
) (
    input  logic                      aresetn,
    input  logic                      aclk,

    input  logic [AXI_ID_WIDTH-1:0]   s0_axi4_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s0_axi4_araddr,
    input  logic [7:0]                s0_axi4_arlen,
    input  logic [2:0]                s0_axi4_arsize,
    input  logic [1:0]                s0_axi4_arburst,
    input  logic [0:0]                s0_axi4_arlock,
    input  logic [3:0]                s0_axi4_arcache,
    input  logic [2:0]                s0_axi4_arprot,
    input  logic [3:0]                s0_axi4_arqos,
    input  logic                      s0_axi4_arvalid,
    output logic                      s0_axi4_arready,
    output logic [AXI_ID_WIDTH-1:0]   s0_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0] s0_axi4_rdata,
    output logic [1:0]                s0_axi4_rresp,
    output logic                      s0_axi4_rlast,
    output logic                      s0_axi4_rvalid,
    input  logic                      s0_axi4_rready,

    input  logic [AXI_ID_WIDTH-1:0]   s1_axi4_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s1_axi4_araddr,
    input  logic [7:0]                s1_axi4_arlen,
    input  logic [2:0]                s1_axi4_arsize,
    input  logic [1:0]                s1_axi4_arburst,
    input  logic [0:0]                s1_axi4_arlock,
    input  logic [3:0]                s1_axi4_arcache,
    input  logic [2:0]                s1_axi4_arprot,
    input  logic [3:0]                s1_axi4_arqos,
    input  logic                      s1_axi4_arvalid,
    output logic                      s1_axi4_arready,
    output logic [AXI_ID_WIDTH-1:0]   s1_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0] s1_axi4_rdata,
    output logic [1:0]                s1_axi4_rresp,
    output logic                      s1_axi4_rlast,
    output logic                      s1_axi4_rvalid,
    input  logic                      s1_axi4_rready,

    output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
    output logic [7:0]                m_axi4_arlen,
    output logic [2:0]                m_axi4_arsize,
    output logic [1:0]                m_axi4_arburst,
    output logic [0:0]                m_axi4_arlock,
    output logic [3:0]                m_axi4_arcache,
    output logic [2:0]                m_axi4_arprot,
    output logic [3:0]                m_axi4_arqos,
    output logic                      m_axi4_arvalid,
    input  logic                      m_axi4_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,

    output logic                      busy,
    output logic                      grant,
    output logic                      err_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
    } ar_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       grant_q, grant_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    ar_t        ar_q, ar_d;

    ar_t  s0_ar, s1_ar;
    logic sel, s0_acc, s1_acc, fwd0, fwd1, beat;

    assign s0_ar = '{id: s0_axi4_arid, addr: s0_axi4_araddr, len: s0_axi4_arlen,
                     size: s0_axi4_arsize, burst: s0_axi4_arburst, lock: s0_axi4_arlock,
                     cache: s0_axi4_arcache, prot: s0_axi4_arprot, qos: s0_axi4_arqos};
    assign s1_ar = '{id: s1_axi4_arid, addr: s1_axi4_araddr, len: s1_axi4_arlen,
                     size: s1_axi4_arsize, burst: s1_axi4_arburst, lock: s1_axi4_arlock,
                     cache: s1_axi4_arcache, prot: s1_axi4_arprot, qos: s1_axi4_arqos};

    // Port 1 wins when it holds priority and requests, or when port 0 is silent.
    assign sel    = prio_q ? s1_axi4_arvalid : ~s0_axi4_arvalid;
    assign s0_acc = aresetn && (state_q == ST_IDLE) && !sel && s0_axi4_arvalid;
    assign s1_acc = aresetn && (state_q == ST_IDLE) &&  sel && s1_axi4_arvalid;

    assign fwd0 = (state_q == ST_R) && !grant_q;
    assign fwd1 = (state_q == ST_R) &&  grant_q;
    assign beat = m_axi4_rvalid && m_axi4_rready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ar_d    = ar_q;
        case (state_q)
            ST_IDLE: begin
                if (s0_acc || s1_acc) begin
                    ar_d    = s1_acc ? s1_ar : s0_ar;
                    grant_d = s1_acc;
                    cnt_d   = 8'd0;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi4_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    // RLAST must coincide exactly with the ARLEN-th beat.
                    if (m_axi4_rlast != (cnt_q == ar_q.len)) begin
                        err_d = 1'b1;
                    end
                    if (m_axi4_rlast) begin
                        state_d = ST_IDLE;
                        prio_d  = ~grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            ar_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ar_q    <= ar_d;
        end
    end

    assign s0_axi4_arready = s0_acc;
    assign s1_axi4_arready = s1_acc;

    assign m_axi4_arvalid = (state_q == ST_AR);
    assign m_axi4_arid    = ar_q.id;
    assign m_axi4_araddr  = ar_q.addr;
    assign m_axi4_arlen   = ar_q.len;
    assign m_axi4_arsize  = ar_q.size;
    assign m_axi4_arburst = ar_q.burst;
    assign m_axi4_arlock  = ar_q.lock;
    assign m_axi4_arcache = ar_q.cache;
    assign m_axi4_arprot  = ar_q.prot;
    assign m_axi4_arqos   = ar_q.qos;

    assign m_axi4_rready = fwd1 ? s1_axi4_rready : (fwd0 && s0_axi4_rready);

    assign s0_axi4_rid    = fwd0 ? m_axi4_rid   : '0;
    assign s0_axi4_rdata  = fwd0 ? m_axi4_rdata : '0;
    assign s0_axi4_rresp  = fwd0 ? m_axi4_rresp : 2'd0;
    assign s0_axi4_rlast  = fwd0 && m_axi4_rlast;
    assign s0_axi4_rvalid = fwd0 && m_axi4_rvalid;

    assign s1_axi4_rid    = fwd1 ? m_axi4_rid   : '0;
    assign s1_axi4_rdata  = fwd1 ? m_axi4_rdata : '0;
    assign s1_axi4_rresp  = fwd1 ? m_axi4_rresp : 2'd0;
    assign s1_axi4_rlast  = fwd1 && m_axi4_rlast;
    assign s1_axi4_rvalid = fwd1 && m_axi4_rvalid;

    assign busy     = (state_q != ST_IDLE);
    assign grant    = grant_q;
    assign err_last = err_q;

endmodule

// File: tb/tb_jelly_axi4_read_arbiter2.sv
// Directed bench for jelly_axi4_read_arbiter2: AR and R scoreboards checked
// by negedge monitors, with immediate-assertion comparisons throughout.
module tb_jelly_axi4_read_arbiter2;

    localparam int unsigned IDW = 6;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;

    logic aclk = 1'b0;
    logic aresetn;

    logic [IDW-1:0] s0_axi4_arid, s1_axi4_arid, m_axi4_arid;
    logic [AW-1:0]  s0_axi4_araddr, s1_axi4_araddr, m_axi4_araddr;
    logic [7:0]     s0_axi4_arlen, s1_axi4_arlen, m_axi4_arlen;
    logic [2:0]     s0_axi4_arsize, s1_axi4_arsize, m_axi4_arsize;
    logic [1:0]     s0_axi4_arburst, s1_axi4_arburst, m_axi4_arburst;
    logic [0:0]     s0_axi4_arlock, s1_axi4_arlock, m_axi4_arlock;
    logic [3:0]     s0_axi4_arcache, s1_axi4_arcache, m_axi4_arcache;
    logic [2:0]     s0_axi4_arprot, s1_axi4_arprot, m_axi4_arprot;
    logic [3:0]     s0_axi4_arqos, s1_axi4_arqos, m_axi4_arqos;
    logic           s0_axi4_arvalid, s1_axi4_arvalid, m_axi4_arvalid;
    logic           s0_axi4_arready, s1_axi4_arready, m_axi4_arready;
    logic [IDW-1:0] s0_axi4_rid, s1_axi4_rid, m_axi4_rid;
    logic [DW-1:0]  s0_axi4_rdata, s1_axi4_rdata, m_axi4_rdata;
    logic [1:0]     s0_axi4_rresp, s1_axi4_rresp, m_axi4_rresp;
    logic           s0_axi4_rlast, s1_axi4_rlast, m_axi4_rlast;
    logic           s0_axi4_rvalid, s1_axi4_rvalid, m_axi4_rvalid;
    logic           s0_axi4_rready, s1_axi4_rready, m_axi4_rready;
    logic           busy, grant, err_last;

    jelly_axi4_read_arbiter2 dut (
        .aresetn(aresetn), .aclk(aclk),
        .s0_axi4_arid(s0_axi4_arid), .s0_axi4_araddr(s0_axi4_araddr), .s0_axi4_arlen(s0_axi4_arlen),
        .s0_axi4_arsize(s0_axi4_arsize), .s0_axi4_arburst(s0_axi4_arburst), .s0_axi4_arlock(s0_axi4_arlock),
        .s0_axi4_arcache(s0_axi4_arcache), .s0_axi4_arprot(s0_axi4_arprot), .s0_axi4_arqos(s0_axi4_arqos),
        .s0_axi4_arvalid(s0_axi4_arvalid), .s0_axi4_arready(s0_axi4_arready),
        .s0_axi4_rid(s0_axi4_rid), .s0_axi4_rdata(s0_axi4_rdata), .s0_axi4_rresp(s0_axi4_rresp),
        .s0_axi4_rlast(s0_axi4_rlast), .s0_axi4_rvalid(s0_axi4_rvalid), .s0_axi4_rready(s0_axi4_rready),
        .s1_axi4_arid(s1_axi4_arid), .s1_axi4_araddr(s1_axi4_araddr), .s1_axi4_arlen(s1_axi4_arlen),
        .s1_axi4_arsize(s1_axi4_arsize), .s1_axi4_arburst(s1_axi4_arburst), .s1_axi4_arlock(s1_axi4_arlock),
        .s1_axi4_arcache(s1_axi4_arcache), .s1_axi4_arprot(s1_axi4_arprot), .s1_axi4_arqos(s1_axi4_arqos),
        .s1_axi4_arvalid(s1_axi4_arvalid), .s1_axi4_arready(s1_axi4_arready),
        .s1_axi4_rid(s1_axi4_rid), .s1_axi4_rdata(s1_axi4_rdata), .s1_axi4_rresp(s1_axi4_rresp),
        .s1_axi4_rlast(s1_axi4_rlast), .s1_axi4_rvalid(s1_axi4_rvalid), .s1_axi4_rready(s1_axi4_rready),
        .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arlen(m_axi4_arlen),
        .m_axi4_arsize(m_axi4_arsize), .m_axi4_arburst(m_axi4_arburst), .m_axi4_arlock(m_axi4_arlock),
        .m_axi4_arcache(m_axi4_arcache), .m_axi4_arprot(m_axi4_arprot), .m_axi4_arqos(m_axi4_arqos),
        .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
        .m_axi4_rid(m_axi4_rid), .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp),
        .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
        .busy(busy), .grant(grant), .err_last(err_last)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [3:0]     qos;
    } ar_exp_t;

    typedef struct {
        int             port;
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } r_exp_t;

    ar_exp_t exp_ar[$];
    r_exp_t  exp_r[$];
    int      n_chk  = 0;
    int      n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic ar_rdy(input int p);
        return (p == 0) ? s0_axi4_arready : s1_axi4_arready;
    endfunction

    // Master-side AR monitor: each accepted request must match the oldest expected one.
    task automatic ar_mon();
        ar_exp_t e;
        if (exp_ar.size() == 0) begin
            chk("ar_unexpected", 64'(m_axi4_arvalid), 64'(0));
        end else begin
            e = exp_ar.pop_front();
            chk("m_arid",    64'(m_axi4_arid),    64'(e.id));
            chk("m_araddr",  64'(m_axi4_araddr),  64'(e.addr));
            chk("m_arlen",   64'(m_axi4_arlen),   64'(e.len));
            chk("m_arqos",   64'(m_axi4_arqos),   64'(e.qos));
            chk("m_arsize",  64'(m_axi4_arsize),  64'(3));
            chk("m_arburst", 64'(m_axi4_arburst), 64'(1));
            chk("m_arlock",  64'(m_axi4_arlock),  64'(0));
            chk("m_arcache", 64'(m_axi4_arcache), 64'(3));
            chk("m_arprot",  64'(m_axi4_arprot),  64'(2));
        end
    endtask

    task automatic r_mon(input int p, input logic v, input logic [IDW-1:0] id,
                         input logic [DW-1:0] data, input logic [1:0] resp, input logic last);
        r_exp_t e;
        if (exp_r.size() == 0) begin
            chk("r_unexpected", 64'(v), 64'(0));
        end else begin
            e = exp_r.pop_front();
            chk("r_port", 64'(p),    64'(e.port));
            chk("r_id",   64'(id),   64'(e.id));
            chk("r_data", data,      e.data);
            chk("r_resp", 64'(resp), 64'(e.resp));
            chk("r_last", 64'(last), 64'(e.last));
        end
    endtask

    always @(negedge aclk) begin
        if (m_axi4_arvalid && m_axi4_arready) ar_mon();
        if (s0_axi4_rvalid && s0_axi4_rready)
            r_mon(0, s0_axi4_rvalid, s0_axi4_rid, s0_axi4_rdata, s0_axi4_rresp, s0_axi4_rlast);
        if (s1_axi4_rvalid && s1_axi4_rready)
            r_mon(1, s1_axi4_rvalid, s1_axi4_rid, s1_axi4_rdata, s1_axi4_rresp, s1_axi4_rlast);
    end

    task automatic set_ar(input int p, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
        ar_exp_t e;
        e.id = id; e.addr = addr; e.len = len; e.qos = (p == 0) ? 4'h5 : 4'hA;
        exp_ar.push_back(e);
        if (p == 0) begin
            s0_axi4_arid = id; s0_axi4_araddr = addr; s0_axi4_arlen = len; s0_axi4_arqos = e.qos;
            s0_axi4_arvalid = 1'b1;
        end else begin
            s1_axi4_arid = id; s1_axi4_araddr = addr; s1_axi4_arlen = len; s1_axi4_arqos = e.qos;
            s1_axi4_arvalid = 1'b1;
        end
    endtask

    task automatic ar_handshake(input int p, output int waited);
        int k = 0;
        #1;
        while (!ar_rdy(p) && k < 30) begin
            @(posedge aclk);
            #2;
            k++;
        end
        waited = k;
        chk("ar_ready",       64'(ar_rdy(p)),      64'(1));
        chk("ar_loser_ready", 64'(ar_rdy(1 - p)),  64'(0));
        chk("m_arvalid_at_N", 64'(m_axi4_arvalid), 64'(0));
        tick();
        if (p == 0) s0_axi4_arvalid = 1'b0;
        else        s1_axi4_arvalid = 1'b0;
    endtask

    task automatic m_ar_accept(input int p, input int hold);
        m_axi4_arready = 1'b0;
        #1;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            chk("m_arvalid_N1", 64'(m_axi4_arvalid), 64'(1));
            chk("grant",        64'(grant),          64'(p));
            chk("busy_ar",      64'(busy),           64'(1));
            chk("arready_in_ar", 64'(s0_axi4_arready | s1_axi4_arready), 64'(0));
            if (exp_ar.size() > 0) begin
                chk("m_araddr_stable", 64'(m_axi4_araddr), 64'(exp_ar[0].addr));
                chk("m_arid_stable",   64'(m_axi4_arid),   64'(exp_ar[0].id));
            end
        end
        m_axi4_arready = 1'b1;
        tick();
        m_axi4_arready = 1'b0;
    endtask

    // Drives n beats from the memory side; the beat with index last_at carries RLAST.
    task automatic send_beats(input int p, input logic [IDW-1:0] id, input int n,
                              input int last_at, input bit toggle);
        bit     ph = 1'b0;
        int     k;
        r_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.port = p; e.id = id; e.data = {$urandom(), $urandom()};
            e.resp = 2'(i); e.last = (i == last_at);
            exp_r.push_back(e);
            m_axi4_rvalid = 1'b1; m_axi4_rid = id; m_axi4_rdata = e.data;
            m_axi4_rresp = e.resp; m_axi4_rlast = e.last;
            k = 0;
            forever begin
                ph = toggle ? ~ph : 1'b1;
                if (p == 0) s0_axi4_rready = ph;
                else        s1_axi4_rready = ph;
                #1;
                chk("other_rvalid", 64'((p == 0) ? s1_axi4_rvalid : s0_axi4_rvalid), 64'(0));
                chk("m_rready",     64'(m_axi4_rready), 64'(ph));
                chk("arready_in_r", 64'(s0_axi4_arready | s1_axi4_arready), 64'(0));
                if (m_axi4_rready || k >= 20) break;
                tick();
                k++;
            end
            chk("r_beat_wait", 64'(k < 20), 64'(1));
            tick();
        end
        m_axi4_rvalid = 1'b0;
        m_axi4_rlast  = 1'b0;
        s0_axi4_rready = 1'b1;
        s1_axi4_rready = 1'b1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_s0_arready", 64'(s0_axi4_arready), 64'(0));
        chk("rst_s1_arready", 64'(s1_axi4_arready), 64'(0));
        chk("rst_s0_rvalid",  64'(s0_axi4_rvalid),  64'(0));
        chk("rst_s1_rvalid",  64'(s1_axi4_rvalid),  64'(0));
        chk("rst_m_arvalid",  64'(m_axi4_arvalid),  64'(0));
        chk("rst_m_rready",   64'(m_axi4_rready),   64'(0));
        chk("rst_busy",       64'(busy),            64'(0));
        chk("rst_grant",      64'(grant),           64'(0));
        chk("rst_err_last",   64'(err_last),        64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        aresetn = 1'b0;
        {s0_axi4_arid, s0_axi4_araddr, s0_axi4_arlen, s0_axi4_arvalid} = '0;
        {s1_axi4_arid, s1_axi4_araddr, s1_axi4_arlen, s1_axi4_arvalid} = '0;
        s0_axi4_arsize = 3'd3; s0_axi4_arburst = 2'd1; s0_axi4_arlock = 1'b0;
        s0_axi4_arcache = 4'd3; s0_axi4_arprot = 3'd2; s0_axi4_arqos = 4'h0;
        s1_axi4_arsize = 3'd3; s1_axi4_arburst = 2'd1; s1_axi4_arlock = 1'b0;
        s1_axi4_arcache = 4'd3; s1_axi4_arprot = 3'd2; s1_axi4_arqos = 4'h0;
        s0_axi4_rready = 1'b1; s1_axi4_rready = 1'b1;
        m_axi4_arready = 1'b0;
        m_axi4_rid = '0; m_axi4_rdata = '0; m_axi4_rresp = 2'd0; m_axi4_rlast = 1'b0;
        m_axi4_rvalid = 1'b1;

        // Reset holds everything quiet even with requests and R traffic present.
        set_ar(0, 6'h05, 32'h0000_1000, 8'd3);
        tick();
        #1;
        chk_reset_outputs();
        tick();
        m_axi4_rvalid = 1'b0;
        aresetn = 1'b1;

        // s0 alone, arlen=3, accepted in the first cycle after reset.
        ar_handshake(0, w);
        chk("first_cycle_accept", 64'(w), 64'(0));
        m_ar_accept(0, 0);
        send_beats(0, 6'h05, 4, 3, 1'b0);
        #1;
        chk("s1_busy_after_last", 64'(busy), 64'(0));
        chk("s1_err_last", 64'(err_last), 64'(0));
        chk("s1_r_sb_empty", 64'(exp_r.size()), 64'(0));
        tick();

        // Simultaneous requests from reset: s0, then s1 with priority, then s0.
        do_reset();
        set_ar(0, 6'h11, 32'h0000_2000, 8'd1);
        set_ar(1, 6'h22, 32'h0000_3000, 8'd2);
        ar_handshake(0, w);
        m_ar_accept(0, 0);
        send_beats(0, 6'h11, 2, 1, 1'b0);
        set_ar(0, 6'h13, 32'h0000_2100, 8'd0);
        ar_handshake(1, w);
        chk("turnaround_next_cycle", 64'(w), 64'(0));
        m_ar_accept(1, 0);
        send_beats(1, 6'h22, 3, 2, 1'b0);
        ar_handshake(0, w);
        m_ar_accept(0, 0);
        send_beats(0, 6'h13, 1, 0, 1'b0);
        #1;
        chk("s2_busy", 64'(busy), 64'(0));
        chk("s2_err_last", 64'(err_last), 64'(0));
        tick();

        // m_arready held low for 5 cycles.
        set_ar(1, 6'h2A, 32'hDEAD_BEE0, 8'd1);
        ar_handshake(1, w);
        m_ar_accept(1, 5);
        send_beats(1, 6'h2A, 2, 1, 1'b0);

        // Granted rready toggling, 6-beat burst.
        set_ar(0, 6'h07, 32'h0000_4000, 8'd5);
        ar_handshake(0, w);
        m_ar_accept(0, 0);
        send_beats(0, 6'h07, 6, 5, 1'b1);
        #1;
        chk("s4_err_last", 64'(err_last), 64'(0));
        chk("s4_busy", 64'(busy), 64'(0));
        tick();

        // Early RLAST on the third beat of an arlen=3 burst.
        set_ar(0, 6'h09, 32'h0000_5000, 8'd3);
        ar_handshake(0, w);
        m_ar_accept(0, 0);
        send_beats(0, 6'h09, 2, -1, 1'b0);
        #1;
        chk("s5a_busy_mid", 64'(busy), 64'(1));
        chk("s5a_err_mid", 64'(err_last), 64'(0));
        send_beats(0, 6'h09, 1, 0, 1'b0);
        #1;
        chk("s5a_busy_end", 64'(busy), 64'(0));
        chk("s5a_err_set", 64'(err_last), 64'(1));
        tick();
        do_reset();
        #1;
        chk("err_cleared_by_reset", 64'(err_last), 64'(0));

        // Late RLAST on the sixth beat of an arlen=3 burst.
        set_ar(1, 6'h0B, 32'h0000_6000, 8'd3);
        ar_handshake(1, w);
        m_ar_accept(1, 0);
        send_beats(1, 6'h0B, 3, -1, 1'b0);
        #1;
        chk("s5b_err_before_len", 64'(err_last), 64'(0));
        send_beats(1, 6'h0B, 1, -1, 1'b0);
        #1;
        chk("s5b_err_missing_last", 64'(err_last), 64'(1));
        chk("s5b_busy_no_last", 64'(busy), 64'(1));
        send_beats(1, 6'h0B, 2, 1, 1'b0);
        #1;
        chk("s5b_busy_end", 64'(busy), 64'(0));
        chk("s5b_err_sticky", 64'(err_last), 64'(1));
        tick();

        // Reset asserted in R after beat 1 abandons the burst.
        do_reset();
        set_ar(0, 6'h0C, 32'h0000_7000, 8'd3);
        ar_handshake(0, w);
        m_ar_accept(0, 0);
        send_beats(0, 6'h0C, 2, -1, 1'b0);
        m_axi4_rvalid = 1'b1; m_axi4_rid = 6'h0C; m_axi4_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        set_ar(1, 6'h0D, 32'h0000_8000, 8'd1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        #1;
        chk("rst_hold_s0_rvalid", 64'(s0_axi4_rvalid), 64'(0));
        tick();
        m_axi4_rvalid = 1'b0;
        aresetn = 1'b1;
        ar_handshake(1, w);
        chk("post_reset_accept", 64'(w), 64'(0));
        m_ar_accept(1, 0);
        send_beats(1, 6'h0D, 2, 1, 1'b0);
        #1;
        chk("s6_busy", 64'(busy), 64'(0));
        chk("s6_err_last", 64'(err_last), 64'(0));
        tick();

        chk("ar_sb_empty", 64'(exp_ar.size()), 64'(0));
        chk("r_sb_empty", 64'(exp_r.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
